// File: rtl/piece_drop_ctrl.sv
// piece_drop_ctrl: falling single-cell piece and per-column skyline for the
// game-control handshake. Consumes the registered game state code and
// reports placed / game_over back to the controller.
// Optional macro HARD_DROP_EN adds a hard_drop input that snaps the piece
// to its column's skyline in one cycle.
module piece_drop_ctrl #(
   parameter int unsigned COLS       = 10,
   parameter int unsigned ROWS       = 20,
   parameter int unsigned GRAV_TICKS = 8,
   parameter int unsigned SPAWN_COL  = 4,
   parameter int unsigned CW         = $clog2(COLS),
   parameter int unsigned RW         = $clog2(ROWS + 1)
) (
   input  logic          clka,
   input  logic          restart,
   input  logic [2:0]    state,
   input  logic          move_left,
   input  logic          move_right,
   input  logic          soft_drop,
`ifdef HARD_DROP_EN
   input  logic          hard_drop,
`endif
   output logic          placed,
   output logic          game_over,
   output logic          active,
   output logic [RW-1:0] piece_row,
   output logic [CW-1:0] piece_col
);

   localparam int unsigned GW = $clog2(GRAV_TICKS);

   localparam logic [2:0] ST_GEN      = 3'b000;
   localparam logic [2:0] ST_MOVE     = 3'b001;
   localparam logic [2:0] ST_LAND     = 3'b010;
   localparam logic [2:0] ST_NEWBOARD = 3'b100;

   logic [RW-1:0] height_q [COLS];
   logic [RW-1:0] height_d [COLS];
   logic [GW-1:0] grav_cnt_q, grav_cnt_d;
   logic          placed_q, placed_d;
   logic          game_over_q, game_over_d;
   logic          active_q, active_d;
   logic [RW-1:0] piece_row_q, piece_row_d;
   logic [CW-1:0] piece_col_q, piece_col_d;

   logic [CW-1:0] col_l_c, col_r_c, tgt_c;
   logic          left_ok_c, right_ok_c, step_c, land_c, hd_c;
   logic [RW-1:0] commit_c;

   // Next-state logic: decode the game state code and update piece/skyline
   always_comb begin
      height_d    = height_q;
      grav_cnt_d  = grav_cnt_q;
      placed_d    = placed_q;
      game_over_d = game_over_q;
      active_d    = active_q;
      piece_row_d = piece_row_q;
      piece_col_d = piece_col_q;

`ifdef HARD_DROP_EN
      hd_c = hard_drop;
`else
      hd_c = 1'b0;
`endif
      col_l_c    = piece_col_q - CW'(1);
      col_r_c    = piece_col_q + CW'(1);
      land_c     = (piece_row_q == height_q[piece_col_q]);
      // Neighbour reads are only meaningful when the edge guard holds
      left_ok_c  = move_left & ~move_right & (piece_col_q != CW'(0)) &
                   (height_q[col_l_c] <= piece_row_q);
      right_ok_c = move_right & ~move_left & (piece_col_q < CW'(COLS - 1)) &
                   (height_q[col_r_c] <= piece_row_q);
      tgt_c      = left_ok_c ? col_l_c : (right_ok_c ? col_r_c : piece_col_q);
      step_c     = (grav_cnt_q == GW'(GRAV_TICKS - 1)) | soft_drop;
      commit_c   = (piece_row_q >= RW'(ROWS - 1)) ? RW'(ROWS)
                                                  : piece_row_q + RW'(1);

      case (state)
         ST_NEWBOARD: begin
            for (int c = 0; c < COLS; c++) height_d[c] = '0;
            grav_cnt_d  = '0;
            placed_d    = 1'b0;
            game_over_d = 1'b0;
            active_d    = 1'b0;
            piece_row_d = RW'(ROWS - 1);
            piece_col_d = CW'(SPAWN_COL);
         end
         ST_GEN: begin
            if (!active_q && !placed_q && !game_over_q) begin
               if (height_q[SPAWN_COL] == RW'(ROWS)) begin
                  game_over_d = 1'b1;
               end else begin
                  piece_row_d = RW'(ROWS - 1);
                  piece_col_d = CW'(SPAWN_COL);
                  active_d    = 1'b1;
                  grav_cnt_d  = '0;
               end
            end
         end
         ST_MOVE: begin
            if (active_q && !placed_q) begin
               if (land_c) begin
                  placed_d = 1'b1;
               end else if (hd_c) begin
                  piece_row_d = height_q[piece_col_q];
                  grav_cnt_d  = '0;
               end else begin
                  piece_col_d = tgt_c;
                  if (step_c) begin
                     grav_cnt_d = '0;
                     if (piece_row_q > height_q[tgt_c]) begin
                        piece_row_d = piece_row_q - RW'(1);
                     end
                  end else begin
                     grav_cnt_d = grav_cnt_q + GW'(1);
                  end
               end
            end
         end
         ST_LAND: begin
            if (placed_q && active_q) begin
               height_d[piece_col_q] = commit_c;
               active_d              = 1'b0;
               placed_d              = 1'b0;
            end
         end
         default: ;
      endcase
   end

   // State registers with synchronous restart
   always_ff @(posedge clka) begin
      if (restart) begin
         for (int c = 0; c < COLS; c++) height_q[c] <= '0;
         grav_cnt_q  <= '0;
         placed_q    <= 1'b0;
         game_over_q <= 1'b0;
         active_q    <= 1'b0;
         piece_row_q <= RW'(ROWS - 1);
         piece_col_q <= CW'(SPAWN_COL);
      end else begin
         height_q    <= height_d;
         grav_cnt_q  <= grav_cnt_d;
         placed_q    <= placed_d;
         game_over_q <= game_over_d;
         active_q    <= active_d;
         piece_row_q <= piece_row_d;
         piece_col_q <= piece_col_d;
      end
   end

   assign placed    = placed_q;
   assign game_over = game_over_q;
   assign active    = active_q;
   assign piece_row = piece_row_q;
   assign piece_col = piece_col_q;

endmodule

// File: tb/tb_piece_drop_ctrl.sv
// Directed testbench for piece_drop_ctrl (default parameters).
module tb_piece_drop_ctrl;

   localparam logic [2:0] GEN      = 3'b000;
   localparam logic [2:0] MOVE     = 3'b001;
   localparam logic [2:0] LAND     = 3'b010;
   localparam logic [2:0] CLEAR    = 3'b011;
   localparam logic [2:0] NEWBOARD = 3'b100;
   localparam logic [2:0] GAMEOVER = 3'b101;

   logic       clka = 1'b0;
   logic       restart = 1'b0;
   logic [2:0] state = NEWBOARD;
   logic       move_left = 1'b0;
   logic       move_right = 1'b0;
   logic       soft_drop = 1'b0;
`ifdef HARD_DROP_EN
   logic       hard_drop = 1'b0;
`endif
   logic       placed, game_over, active;
   logic [4:0] piece_row;
   logic [3:0] piece_col;

   int n_tests = 0;
   int n_fail  = 0;
   int r;

   piece_drop_ctrl dut (
      .clka       (clka),
      .restart    (restart),
      .state      (state),
      .move_left  (move_left),
      .move_right (move_right),
      .soft_drop  (soft_drop),
`ifdef HARD_DROP_EN
      .hard_drop  (hard_drop),
`endif
      .placed     (placed),
      .game_over  (game_over),
      .active     (active),
      .piece_row  (piece_row),
      .piece_col  (piece_col)
   );

   always #5 clka = ~clka;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clka);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_active"}, int'(active), 0);
      chk({tag, "_placed"}, int'(placed), 0);
      chk({tag, "_go"}, int'(game_over), 0);
      chk({tag, "_row"}, int'(piece_row), 19);
      chk({tag, "_col"}, int'(piece_col), 4);
   endtask

   // One GEN cycle, then park in MOVE
   task automatic spawn();
      state = GEN;
      tick();
      chk("spawn_active", int'(active), 1);
      chk("spawn_row", int'(piece_row), 19);
      chk("spawn_col", int'(piece_col), 4);
      state = MOVE;
   endtask

   // Soft-drop while steering toward col until placed, then commit via LAND
   task automatic fall(input int col, output int row_at);
      soft_drop = 1'b1;
      for (int k = 0; k < 50 && placed !== 1'b1; k++) begin
         move_left  = (int'(piece_col) > col);
         move_right = (int'(piece_col) < col);
         tick();
      end
      soft_drop = 1'b0; move_left = 1'b0; move_right = 1'b0;
      chk("fall_placed", int'(placed), 1);
      chk("fall_col", int'(piece_col), col);
      row_at = int'(piece_row);
      state = LAND;
      tick();
      chk("fall_commit", int'(active), 0);
   endtask

   initial begin
      // Reset
      restart = 1'b1;
      tick();
      restart = 1'b0;
      chk_reset("reset");

      // Spawn; repeated GEN does not respawn
      spawn();
      chk("spawn_placed", int'(placed), 0);
      state = GEN;
      tick();
      chk("regen_row", int'(piece_row), 19);
      chk("regen_active", int'(active), 1);

      // Gravity: one row per 8 MOVE cycles
      state = MOVE;
      tick(7);
      chk("grav_7", int'(piece_row), 19);
      tick();
      chk("grav_8", int'(piece_row), 18);
      state = CLEAR;
      tick(3);
      chk("clear_hold", int'(piece_row), 18);
      state = MOVE;
      tick(144);
      chk("grav_row0", int'(piece_row), 0);
      chk("grav_row0_placed", int'(placed), 0);
      tick();
      chk("grav_placed", int'(placed), 1);
      move_left = 1'b1; soft_drop = 1'b1;
      tick(2);
      move_left = 1'b0; soft_drop = 1'b0;
      chk("placed_hold_col", int'(piece_col), 4);
      chk("placed_hold_row", int'(piece_row), 0);
      chk("placed_hold", int'(placed), 1);
      state = LAND;
      tick();
      chk("land_active", int'(active), 0);
      chk("land_placed", int'(placed), 0);
      tick();
      chk("land_again", int'(active), 0);

      // height[4]=1 -> next piece lands at row 1
      spawn();
      fall(4, r);
      chk("stack_row1", r, 1);

      // Lateral moves; height[4]=2 now
      spawn();
      move_left = 1'b1;
      tick(5);
      chk("left5_col", int'(piece_col), 0);
      move_right = 1'b1;
      tick(3);
      chk("both_col", int'(piece_col), 0);
      move_left = 1'b0;
      tick(2);
      move_right = 1'b0;
      chk("right2_col", int'(piece_col), 2);
      chk("lat_grav_row", int'(piece_row), 18);
      fall(2, r);
      chk("col2_row", r, 0);

      // Build height[3]=10
      for (int i = 0; i < 10; i++) begin
         spawn();
         fall(3, r);
         chk("col3_row", r, i);
      end
      spawn();
      soft_drop = 1'b1;
      tick(14);
      soft_drop = 1'b0;
      chk("blk_row", int'(piece_row), 5);
      move_left = 1'b1;
      tick();
      move_left = 1'b0;
      chk("blk_left_col", int'(piece_col), 4);
      chk("blk_left_row", int'(piece_row), 5);
      fall(4, r);
      chk("col4_row2", r, 2);

      // Soft drop every cycle onto height[4]=3
      spawn();
      soft_drop = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         tick();
         chk("soft_row", int'(piece_row), 19 - i);
      end
      chk("soft_noplace", int'(placed), 0);
      tick();
      chk("soft_placed", int'(placed), 1);
      chk("soft_land_row", int'(piece_row), 3);
      soft_drop = 1'b0;
      state = LAND;
      tick();

      // Restart mid-fall
      spawn();
      soft_drop = 1'b1;
      tick(5);
      chk("midfall_row", int'(piece_row), 14);
      restart = 1'b1;
      tick();
      restart = 1'b0; soft_drop = 1'b0;
      chk_reset("restart");

      // Stack 20 in column 4, then spawn is blocked
      for (int i = 0; i < 20; i++) begin
         spawn();
         fall(4, r);
         chk("stack20_row", r, i);
      end
      state = GEN;
      tick();
      chk("go_set", int'(game_over), 1);
      chk("go_active", int'(active), 0);
      state = GAMEOVER;
      tick(3);
      chk("go_hold", int'(game_over), 1);
      state = GEN;
      tick();
      chk("go_gen_hold", int'(game_over), 1);
      chk("go_gen_active", int'(active), 0);
      state = NEWBOARD;
      tick();
      chk_reset("newboard");
      spawn();
      fall(4, r);
      chk("nb_cleared", r, 0);

`ifdef HARD_DROP_EN
      for (int i = 1; i < 7; i++) begin
         spawn();
         fall(4, r);
      end
      spawn();
      hard_drop = 1'b1;
      tick();
      hard_drop = 1'b0;
      chk("hd_row", int'(piece_row), 7);
      chk("hd_noplace", int'(placed), 0);
      tick();
      chk("hd_placed", int'(placed), 1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
